// File: rtl/uart_tx_sched.sv
// Transmit-side character scheduler: circular FIFO (or single holding register),
// THRE/TEMT status, threshold interrupt and sticky overrun flag.
module uart_tx_sched #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              utrst,
  input  logic              fifo_en,
  input  logic              tx_fifo_rst,
  input  logic [1:0]        trig_level,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tsr_load,
  input  logic              tx_idle,
  input  logic              err_clr,
  output logic [DATA_W-1:0] tsr_data,
  output logic              thre,
  output logic              temt,
  output logic              full,
  output logic [AW:0]       count,
  output logic              tx_trig_irq,
  output logic              overrun_err
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_fifo_en;
  logic              r_irq;
  logic              r_ovr;

  logic              w_flush;
  logic [AW:0]       w_cap;
  logic              w_empty;
  logic              w_pop;
  logic              w_wr_acc;
  logic              w_wr_rej;
  logic [AW+3:0]     w_thresh;
  logic              w_irq_nxt;

  // Any mode change empties the buffer so stale characters never leak across modes.
  assign w_flush  = prst | tx_fifo_rst | ~utrst | (fifo_en ^ r_fifo_en);
  assign w_cap    = fifo_en ? (AW+1)'(DEPTH) : (AW+1)'(1);
  assign w_empty  = (r_count == '0);
  assign w_pop    = tsr_load & ~w_flush & ~w_empty;
  assign w_wr_acc = wr_en & ~w_flush & ((r_count < w_cap) | w_pop);
  assign w_wr_rej = wr_en & ~w_flush & ~w_wr_acc;

  always_comb begin
    w_thresh = '0;
    case (trig_level)
      2'b01:   w_thresh = (AW+4)'(2);
      2'b10:   w_thresh = (AW+4)'(4);
      2'b11:   w_thresh = (AW+4)'(8);
      default: w_thresh = '0;
    endcase
  end

  assign w_irq_nxt = fifo_en ? ({3'b000, r_count} <= w_thresh) : w_empty;

  always_ff @(posedge pclk) begin
    r_fifo_en <= fifo_en;
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
  end

  // Status registers: set of overrun takes precedence over its clear.
  always_ff @(posedge pclk) begin
    if (prst) begin
      r_ovr <= 1'b0;
      r_irq <= 1'b1;
    end else begin
      if (w_wr_rej)     r_ovr <= 1'b1;
      else if (err_clr) r_ovr <= 1'b0;
      r_irq <= w_irq_nxt;
    end
  end

  assign tsr_data    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign thre        = w_empty;
  assign temt        = w_empty & tx_idle;
  assign full        = (r_count == w_cap);
  assign count       = r_count;
  assign tx_trig_irq = r_irq;
  assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queue-based reference model, directed and random scenarios.
module tb_uart_tx_sched;
  logic       pclk = 1'b0;
  logic       prst = 1'b1;
  logic       utrst = 1'b1;
  logic       fifo_en = 1'b1;
  logic       tx_fifo_rst = 1'b0;
  logic [1:0] trig_level = 2'b00;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tsr_load = 1'b0;
  logic       tx_idle = 1'b1;
  logic       err_clr = 1'b0;
  logic [7:0] tsr_data;
  logic       thre, temt, full, tx_trig_irq, overrun_err;
  logic [4:0] count;

  logic [7:0] mq[$];
  bit         m_ovr = 1'b0;
  bit         m_irq = 1'b1;
  bit         m_fen_prev = 1'b1;
  int         n_cmp = 0;
  int         n_bad = 0;

  wire [18:0] dut_vec = {count, thre, full, tsr_data, temt, tx_trig_irq, overrun_err};

  uart_tx_sched #(.DEPTH(16), .DATA_W(8), .AW(4)) dut (
    .pclk(pclk), .prst(prst), .utrst(utrst), .fifo_en(fifo_en),
    .tx_fifo_rst(tx_fifo_rst), .trig_level(trig_level), .wr_en(wr_en),
    .wr_data(wr_data), .tsr_load(tsr_load), .tx_idle(tx_idle), .err_clr(err_clr),
    .tsr_data(tsr_data), .thre(thre), .temt(temt), .full(full), .count(count),
    .tx_trig_irq(tx_trig_irq), .overrun_err(overrun_err)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1ms;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  function automatic int thr_of(logic [1:0] t);
    case (t)
      2'b01:   return 2;
      2'b10:   return 4;
      2'b11:   return 8;
      default: return 0;
    endcase
  endfunction

  // Reference model: one clock edge applied to a character queue.
  task automatic model_step();
    int n   = mq.size();
    int cap = fifo_en ? 16 : 1;
    bit flush = prst || tx_fifo_rst || !utrst || (fifo_en != m_fen_prev);
    bit pop   = tsr_load && (n > 0);
    bit acc   = wr_en && ((n < cap) || pop);
    m_fen_prev = fifo_en;
    if (prst) m_irq = 1'b1;
    else      m_irq = fifo_en ? (n <= thr_of(trig_level)) : (n == 0);
    if (prst)                           m_ovr = 1'b0;
    else if (!flush && wr_en && !acc)   m_ovr = 1'b1;
    else if (err_clr)                   m_ovr = 1'b0;
    if (flush) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(wr_data);
    end
  endtask

  function automatic logic [18:0] exp_vec();
    int n   = mq.size();
    int cap = fifo_en ? 16 : 1;
    logic [7:0] head = 8'h00;
    if (n > 0) head = mq[0];
    return {5'(n), 1'(n == 0), 1'(n == cap), head, 1'((n == 0) && tx_idle), 1'(m_irq), 1'(m_ovr)};
  endfunction

  task automatic cyc();
    tx_idle = 1'($urandom_range(0, 1));
    @(posedge pclk);
    model_step();
    @(negedge pclk);
  endtask

  task automatic quiet();
    wr_en = 1'b0; tsr_load = 1'b0; err_clr = 1'b0; tx_fifo_rst = 1'b0;
  endtask

  task automatic test_reset();
    prst = 1'b1; cyc(); prst = 1'b0;
    fifo_en = 1'b0; cyc();
    wr_en = 1'b1; wr_data = 8'hAA; cyc();
    wr_data = 8'hBB; cyc();
    wr_en = 1'b0; cyc();
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL pre_reset: got %h want %h", dut_vec, exp_vec());
    end
    n_cmp++;
    fifo_en = 1'b1; prst = 1'b1; wr_en = 1'b1; wr_data = 8'hCC; cyc();
    prst = 1'b0; wr_en = 1'b0;
    if (dut_vec !== {5'd0, 1'b1, 1'b0, 8'h00, tx_idle, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", dut_vec, {5'd0, 1'b1, 1'b0, 8'h00, tx_idle, 1'b1, 1'b0});
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h41 + i); cyc();
    end
    wr_en = 1'b0;
    if ({count, thre, tsr_data} !== {5'd3, 1'b0, 8'h41}) begin
      n_bad++; $display("FAIL basic_fill: got %h want %h", {count, thre, tsr_data}, {5'd3, 1'b0, 8'h41});
    end
    n_cmp++;
    for (int i = 0; i < 3; i++) begin
      if (tsr_data !== 8'(8'h41 + i)) begin
        n_bad++; $display("FAIL basic_pop%0d: got %h want %h", i, tsr_data, 8'(8'h41 + i));
      end
      n_cmp++;
      tsr_load = 1'b1; cyc();
    end
    tsr_load = 1'b0;
    if ({thre, tsr_data} !== {1'b1, 8'h00}) begin
      n_bad++; $display("FAIL basic_empty: got %h want %h", {thre, tsr_data}, {1'b1, 8'h00});
    end
    n_cmp++;
  endtask

  task automatic test_full_overrun();
    logic [7:0] h = 8'h00;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      if (i == 0) h = wr_data;
      cyc();
    end
    wr_en = 1'b0;
    if ({full, count, overrun_err, tsr_data} !== {1'b1, 5'd16, 1'b1, h}) begin
      n_bad++; $display("FAIL overrun_full: got %h want %h", {full, count, overrun_err, tsr_data}, {1'b1, 5'd16, 1'b1, h});
    end
    n_cmp++;
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    if (overrun_err !== 1'b0) begin
      n_bad++; $display("FAIL overrun_clear: got %b want 0", overrun_err);
    end
    n_cmp++;
    wr_en = 1'b1; tsr_load = 1'b1; wr_data = 8'($urandom); cyc(); quiet();
    if ({count, overrun_err} !== {5'd16, 1'b0} || dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL full_wr_pop: got %h want %h", dut_vec, exp_vec());
    end
    n_cmp++;
    for (int i = 0; i < 17; i++) begin
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL full_drain%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      n_cmp++;
      tsr_load = 1'b1; cyc();
    end
    tsr_load = 1'b0;
  endtask

  task automatic test_holding();
    fifo_en = 1'b0; cyc();
    wr_en = 1'b1; wr_data = 8'h55; cyc();
    if ({full, count, tx_trig_irq} !== {1'b1, 5'd1, 1'b1}) begin
      n_bad++; $display("FAIL hold_first: got %h want %h", {full, count, tx_trig_irq}, {1'b1, 5'd1, 1'b1});
    end
    n_cmp++;
    wr_data = 8'h66; cyc(); wr_en = 1'b0;
    if ({overrun_err, tsr_data, tx_trig_irq} !== {1'b1, 8'h55, 1'b0}) begin
      n_bad++; $display("FAIL hold_drop: got %h want %h", {overrun_err, tsr_data, tx_trig_irq}, {1'b1, 8'h55, 1'b0});
    end
    n_cmp++;
    tsr_load = 1'b1; cyc(); tsr_load = 1'b0;
    cyc();
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL hold_after_pop: got %h want %h", dut_vec, exp_vec());
    end
    n_cmp++;
  endtask

  task automatic test_wrap();
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int written = 0;
    int cycles = 0;
    fifo_en = 1'b1; err_clr = 1'b1; cyc(); err_clr = 1'b0;
    while ((written < 40 || mq.size() > 0) && cycles < 400) begin
      wr_en = (written < 40) && ($urandom_range(0, 3) != 0);
      wr_data = 8'($urandom);
      tsr_load = (mq.size() >= 12) || ((mq.size() >= 10 || written >= 40) && ($urandom_range(0, 2) != 0));
      if (wr_en) begin sent.push_back(wr_data); written++; end
      if (tsr_load && mq.size() > 0) got.push_back(tsr_data);
      cyc(); cycles++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL wrap_cycle%0d: got %h want %h", cycles, dut_vec, exp_vec());
      end
      n_cmp++;
    end
    quiet();
    if (got.size() != 40) begin
      n_bad++; $display("FAIL wrap_len: got %0d want 40", got.size());
    end
    n_cmp++;
    for (int i = 0; i < 40 && i < got.size(); i++) begin
      if (got[i] !== sent[i]) begin
        n_bad++; $display("FAIL wrap_order%0d: got %h want %h", i, got[i], sent[i]);
      end
      n_cmp++;
    end
  endtask

  task automatic test_trig();
    trig_level = 2'b10;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom); cyc();
    end
    wr_en = 1'b0; cyc();
    if ({count, tx_trig_irq} !== {5'd6, 1'b0}) begin
      n_bad++; $display("FAIL trig_at6: got %h want %h", {count, tx_trig_irq}, {5'd6, 1'b0});
    end
    n_cmp++;
    tsr_load = 1'b1; cyc(); cyc(); tsr_load = 1'b0;
    if ({count, tx_trig_irq} !== {5'd4, 1'b0}) begin
      n_bad++; $display("FAIL trig_at4: got %h want %h", {count, tx_trig_irq}, {5'd4, 1'b0});
    end
    n_cmp++;
    cyc();
    if ({count, tx_trig_irq} !== {5'd4, 1'b1}) begin
      n_bad++; $display("FAIL trig_rise: got %h want %h", {count, tx_trig_irq}, {5'd4, 1'b1});
    end
    n_cmp++;
    tsr_load = 1'b1; for (int i = 0; i < 4; i++) cyc(); tsr_load = 1'b0;
    trig_level = 2'b00;
  endtask

  task automatic test_flush();
    bit exp_ovr;
    fifo_en = 1'b0; cyc();
    wr_en = 1'b1; cyc(); cyc(); wr_en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      fifo_en = 1'b1; utrst = 1'b1; cyc();
      for (int i = 0; i < 5; i++) begin
        wr_en = 1'b1; wr_data = 8'($urandom); cyc();
      end
      wr_en = 1'b0;
      if (count !== 5'd5) begin
        n_bad++; $display("FAIL flush%0d_fill: got %0d want 5", s, count);
      end
      n_cmp++;
      exp_ovr = m_ovr;
      case (s)
        0:       tx_fifo_rst = 1'b1;
        1:       utrst = 1'b0;
        default: fifo_en = 1'b0;
      endcase
      wr_en = 1'b1; tsr_load = 1'b1; wr_data = 8'($urandom); cyc();
      wr_en = 1'b0; tsr_load = 1'b0; tx_fifo_rst = 1'b0;
      if ({count, thre, overrun_err} !== {5'd0, 1'b1, exp_ovr}) begin
        n_bad++; $display("FAIL flush%0d_clear: got %h want %h", s, {count, thre, overrun_err}, {5'd0, 1'b1, exp_ovr});
      end
      n_cmp++;
      if (s == 1) begin
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
          cyc();
          if ({thre, overrun_err} !== {1'b1, exp_ovr}) begin
            n_bad++; $display("FAIL flush_utrst_hold%0d: got %h want %h", i, {thre, overrun_err}, {1'b1, exp_ovr});
          end
          n_cmp++;
        end
        wr_en = 1'b0; utrst = 1'b1;
      end
      cyc();
      if (count !== 5'd0 || dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL flush%0d_after: got %h want %h", s, dut_vec, exp_vec());
      end
      n_cmp++;
    end
    fifo_en = 1'b1; cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      prst        = ($urandom_range(0, 99) == 0);
      tx_fifo_rst = ($urandom_range(0, 49) == 0);
      utrst       = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 59) == 0) fifo_en = ~fifo_en;
      if ($urandom_range(0, 19) == 0) trig_level = 2'($urandom);
      wr_en    = ($urandom_range(0, 9) < 6);
      wr_data  = 8'($urandom);
      tsr_load = ($urandom_range(0, 1) == 0);
      err_clr  = ($urandom_range(0, 7) == 0);
      cyc();
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      n_cmp++;
    end
    prst = 1'b0; utrst = 1'b1; quiet();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overrun();
    test_holding();
    test_wrap();
    test_trig();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
